// File: rtl/count_bcd_display.sv
// Tick-driven up/down counter with a double-dabble BCD converter driving active-low seven-segment digits.
// Latency: count change to hex update is WIDTH+2 cycles from IDLE; no backpressure, inputs are always accepted.
module count_bcd_display #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 5,
    parameter int WIDTH   = 8,
    parameter int DIGITS  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  down,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  blank,
    output logic [WIDTH-1:0]      count,
    output logic                  tick,
    output logic                  busy,
    output logic                  ovf,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int DW   = $clog2(DIV);
    localparam int BCDN = (WIDTH * 30103 + 99999) / 100000 + 1;
    localparam int NB   = (BCDN > DIGITS) ? BCDN : DIGITS;
    localparam int CW   = $clog2(WIDTH + 1);

    localparam logic [DW-1:0] DIV_MAX   = DW'(DIV - 1);
    localparam logic [CW-1:0] ITER_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    state_t                 state, state_nx;
    logic [DW-1:0]          div;
    logic [CW-1:0]          iter;
    logic [WIDTH-1:0]       cap, last, sreg;
    logic [4*NB-1:0]        bcd, bcd_adj;
    logic [4*DIGITS-1:0]    disp;
    logic                   upper_nz;
    logic                   lead;
    logic [3:0]             dig;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
    endfunction

    // A load on the same edge as a divider wrap discards that tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div   <= '0;
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (load) begin
                count <= load_value;
                div   <= '0;
            end else if (run) begin
                if (div == DIV_MAX) begin
                    div   <= '0;
                    tick  <= 1'b1;
                    count <= down ? count - WIDTH'(1) : count + WIDTH'(1);
                end else begin
                    div <= div + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (count != last) state_nx = SHIFT;
            SHIFT:   if (iter == ITER_LAST) state_nx = UPDATE;
            UPDATE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NB; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        upper_nz = 1'b0;
        for (int i = DIGITS; i < NB; i++) begin
            if (bcd[4*i +: 4] != 4'd0) upper_nz = 1'b1;
        end
    end

    // cap holds the value being converted; sreg is consumed bit by bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            iter <= '0;
            cap  <= '0;
            last <= '0;
            sreg <= '0;
            bcd  <= '0;
            disp <= '0;
            busy <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_nx == SHIFT) begin
                        cap  <= count;
                        sreg <= count;
                        bcd  <= '0;
                        iter <= '0;
                        busy <= 1'b1;
                    end
                end
                SHIFT: begin
                    bcd  <= {bcd_adj[4*NB-2:0], sreg[WIDTH-1]};
                    sreg <= {sreg[WIDTH-2:0], 1'b0};
                    iter <= iter + CW'(1);
                end
                UPDATE: begin
                    disp <= bcd[4*DIGITS-1:0];
                    last <= cap;
                    ovf  <= upper_nz;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Walk from the top digit down; leading zeros blank until the first nonzero digit.
    always_comb begin
        hex  = '1;
        lead = 1'b1;
        dig  = 4'd0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            dig = disp[4*k +: 4];
            if (ovf) begin
                hex[7*k +: 7] = 7'b1111110;
            end else if (blank && lead && (k != 0) && (dig == 4'd0)) begin
                hex[7*k +: 7] = 7'b1111111;
            end else begin
                hex[7*k +: 7] = seg(dig);
                lead          = 1'b0;
            end
        end
    end

endmodule
